// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
// State encodings are fixed so waveforms match across tools.
package serial_adder_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder built from two half adders and an OR.
// Combinational, reusable outside the serial adder.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s1;
  logic c1;
  logic c2;

  half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (s1),
    .c (c1)
  );

  half_adder u_ha1 (
    .a (s1),
    .b (ci),
    .s (s),
    .c (c2)
  );

  assign co = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per clock, LSB first.
// Result registers update only on entry to DONE.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] acc;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             fa_s;
  logic             fa_c;

  full_adder u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_c)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      acc     <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sr    <= a;
            b_sr    <= b;
            carry_q <= cin;
            cnt     <= '0;
          end
        end
        SHIFT: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          acc     <= {fa_s, acc[WIDTH-1:1]};
          carry_q <= fa_c;
          // hold at the last index so the counter never wraps
          if (!last) cnt <= cnt + 1'b1;
          if (last) begin
            sum  <= {fa_s, acc[WIDTH-1:1]};
            cout <= fa_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int checks;
  int failures;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(
    input  logic [7:0] ta,
    input  logic [7:0] tb,
    input  logic       tc,
    output logic [7:0] s,
    output logic       c,
    output int         lat,
    output int         bcyc,
    output logic       done_after,
    output logic       busy_after
  );
    a = ta; b = tb; cin = tc; start = 1'b1;
    tick();
    start = 1'b0;
    a = 8'hxx; b = 8'hxx; cin = 1'bx;
    lat  = 0;
    bcyc = busy ? 1 : 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
      if (busy) bcyc++;
    end
    s = sum;
    c = cout;
    tick();
    done_after = done;
    busy_after = busy;
  endtask

  task automatic test_reset();
    int nd;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if ({busy, done, sum, cout} !== 11'h0) begin
      failures++;
      $display("FAIL reset_state got=%h want=000", {busy, done, sum, cout});
    end
    nd = 0;
    repeat (12) begin
      tick();
      if (done || busy) nd++;
    end
    checks++;
    if (nd !== 0) begin
      failures++;
      $display("FAIL idle_no_done got=%0d want=0", nd);
    end
  endtask

  task automatic test_basic();
    logic [7:0] s;
    logic c, da, ba;
    int lat, bc;
    run_op(8'h7F, 8'h01, 1'b0, s, c, lat, bc, da, ba);
    checks++;
    if (lat !== 8) begin
      failures++;
      $display("FAIL basic_latency got=%0d want=8", lat);
    end
    checks++;
    if ({c, s} !== 9'h080) begin
      failures++;
      $display("FAIL basic_sum got=%h want=080", {c, s});
    end
    checks++;
    if (bc !== 9) begin
      failures++;
      $display("FAIL basic_busy_cycles got=%0d want=9", bc);
    end
    checks++;
    if ({da, ba} !== 2'b00) begin
      failures++;
      $display("FAIL basic_done_pulse got=%b want=00", {da, ba});
    end
  endtask

  task automatic test_carry();
    logic [7:0] s;
    logic c, da, ba;
    int lat, bc;
    run_op(8'hFF, 8'h01, 1'b0, s, c, lat, bc, da, ba);
    checks++;
    if ({c, s} !== 9'h100) begin
      failures++;
      $display("FAIL carry_ff01 got=%h want=100", {c, s});
    end
    run_op(8'h3C, 8'h41, 1'b1, s, c, lat, bc, da, ba);
    checks++;
    if ({c, s} !== 9'h07E) begin
      failures++;
      $display("FAIL mixed_3c41 got=%h want=07e", {c, s});
    end
    run_op(8'hA5, 8'h5A, 1'b1, s, c, lat, bc, da, ba);
    checks++;
    if ({c, s} !== 9'h100) begin
      failures++;
      $display("FAIL carry_a55a got=%h want=100", {c, s});
    end
  endtask

  task automatic test_start_ignored();
    int nd;
    logic [8:0] res;
    a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    nd = 0;
    res = '0;
    for (int e = 1; e <= 14; e++) begin
      start = (e == 4);
      if (e == 4) begin a = 8'hF0; b = 8'hF0; end
      tick();
      if (done) begin
        nd++;
        res = {cout, sum};
      end
    end
    start = 1'b0;
    checks++;
    if (nd !== 1) begin
      failures++;
      $display("FAIL ignore_done_count got=%0d want=1", nd);
    end
    checks++;
    if (res !== 9'h007) begin
      failures++;
      $display("FAIL ignore_sum got=%h want=007", res);
    end
  endtask

  task automatic test_abort();
    int nd;
    logic [7:0] s;
    logic c, da, ba;
    int lat, bc;
    a = 8'h55; b = 8'h55; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, sum, cout} !== 11'h0) begin
      failures++;
      $display("FAIL abort_outputs got=%h want=000", {busy, done, sum, cout});
    end
    nd = 0;
    repeat (3) begin
      tick();
      if (done) nd++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      tick();
      if (done) nd++;
    end
    checks++;
    if (nd !== 0) begin
      failures++;
      $display("FAIL abort_no_done got=%0d want=0", nd);
    end
    run_op(8'h10, 8'h20, 1'b0, s, c, lat, bc, da, ba);
    checks++;
    if ({c, s} !== 9'h030) begin
      failures++;
      $display("FAIL after_abort_sum got=%h want=030", {c, s});
    end
  endtask

  task automatic test_back_to_back();
    int nd;
    int last_e;
    int bad_gap;
    int bad_sum;
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    nd = 0; last_e = -1; bad_gap = 0; bad_sum = 0;
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (done) begin
        if (last_e >= 0 && (e - last_e) != 10) bad_gap++;
        if ({cout, sum} !== 9'h002) bad_sum++;
        last_e = e;
        nd++;
      end
    end
    start = 1'b0;
    checks++;
    if (nd !== 3) begin
      failures++;
      $display("FAIL b2b_done_count got=%0d want=3", nd);
    end
    checks++;
    if (bad_gap !== 0) begin
      failures++;
      $display("FAIL b2b_spacing got=%0d bad gaps want=0", bad_gap);
    end
    checks++;
    if (bad_sum !== 0) begin
      failures++;
      $display("FAIL b2b_sum got=%0d bad sums want=0", bad_sum);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_carry();
    test_start_ignored();
    test_abort();
    test_back_to_back();
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
